store_narrow_buffer: RTL
========================

// Module: store_narrow_buffer
// PURPOSE
//  MEM-stage store path. Narrows 32-bit register data to byte, halfword or word
//  stores and generates per-byte write enables; this is the store-side counterpart
//  of load sign/zero extension. Queues stores in a DEPTH-entry write buffer that
//  drains to data memory over a valid/ready handshake. Flags misaligned stores.
// PARAMETERS
//  DEPTH   4   write-buffer entries; power of 2, >=2
//  CNT_W   3   width of count; equals clog2(DEPTH+1)
// PORTS
//  clk          in   1      clock; all logic on rising edge
//  rst          in   1      synchronous, active-high reset
//  st_valid     in   1      store request from MEM stage
//  st_addr      in   32     byte address
//  st_data      in   32     register data; low bits used for sb/sh
//  st_size      in   2      00 byte, 01 half, 10 word, 11 illegal
//  st_ready     out  1      buffer can accept; combinational, equals !full
//  st_misalign  out  1      registered one-cycle pulse; store dropped
//  mem_valid    out  1      head entry presented to memory
//  mem_addr     out  32     word address {addr[31:2],2'b00}
//  mem_wdata    out  32     lane-replicated write data
//  mem_be       out  4      byte enables; bit i is lane i, bits [8i+7:8i]
//  mem_ready    in   1      memory accepts head this cycle
//  empty        out  1      count==0
//  count        out  CNT_W  occupied entries
// BEHAVIOUR
//  - Reset: pointers=0, count=0, empty=1, st_misalign=0, mem_valid=0.
//    mem_addr, mem_wdata and mem_be read 0 whenever empty.
//    Reset mid-drain discards all entries; no further mem_valid.
//  - Push when st_valid && st_ready && aligned. Pop when mem_valid && mem_ready.
//  - Full: st_ready=0 even if a pop occurs that cycle; no bypass.
//  - Simultaneous push and pop, not full: count unchanged; both pointers advance.
//  - Pointers wrap modulo DEPTH.
//  - Lane mapping is little-endian; byte lane = st_addr[1:0].
//    - byte: wdata={4{d[7:0]}}; be=4'b0001<<addr[1:0]
//    - half: wdata={2{d[15:0]}}; be=addr[1]?4'b1100:4'b0011
//    - word: wdata=d; be=4'b1111
//  - Misaligned cases: half with addr[0]=1, word with addr[1:0]!=0, size 11.
//    A misaligned store is not enqueued and st_misalign=1 the next cycle.
//    st_ready is unaffected by misalignment.
//  - Latency: a push at edge N into an empty buffer gives mem_valid=1 in cycle N+1.
//  - Order is FIFO.
//  - Head outputs hold stable while mem_valid && !mem_ready.
//  - mem_valid = !empty.
// CONFIGURATION
//  STORE_COALESCE_EN defined:
//    - A push whose word address equals the tail entry's merges into the tail
//      when count>=2; the head entry is never modified.
//    - Merge: be_tail |= be_new; lanes set in be_new overwrite tail data.
//    - A merge leaves count and wr_ptr unchanged; st_ready is still !full.
//    - A concurrent pop is allowed and decrements count.
//  STORE_COALESCE_EN undefined: every accepted store takes a new entry;
//  no address compare logic is present.
// TESTING
//  1. sb addr=0x103, data=0x000000AB, mem_ready=1 -> next cycle mem_valid=1,
//     mem_addr=0x100, wdata=0xABABABAB, be=1000.
//  2. sh addr=0x202, data=0x1234 -> wdata=0x12341234, be=1100;
//     sw addr=0x204 -> be=1111, wdata=st_data.
//  3. sh addr=0x201 and sw addr=0x302 -> st_misalign pulses 1 cycle each;
//     count stays 0; mem_valid stays 0.
//  4. mem_ready=0, push 4 stores -> count=4, st_ready=0; 5th request ignored;
//     raise mem_ready -> 4 pops in order, empty=1.
//  5. Buffer full, push with pop the same cycle -> push refused, count=3.
//     Then rst mid-drain -> count=0, mem_valid=0 the next cycle.
//  6. Coalesce: hold mem_ready=0; sw 0x400, sb 0x500 val 0x11, sb 0x501 val 0x22
//     -> EN: count=2, tail be=0011, wdata[15:0]=0x2211.
//     Without EN: count=3.

Source files
------------

// File: rtl/store_narrow_buffer_if.sv
// Store-path bus: MEM-stage store request side and data-memory drain side.
// Latency and backpressure are set by the store_narrow_buffer that owns the slave modport.
interface store_narrow_buffer_if #(
   parameter int CNT_W = 3
);
   logic             st_valid;
   logic [31:0]      st_addr;
   logic [31:0]      st_data;
   logic [1:0]       st_size;
   logic             st_ready;
   logic             st_misalign;
   logic             mem_valid;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic [3:0]       mem_be;
   logic             mem_ready;
   logic             empty;
   logic [CNT_W-1:0] count;

   modport slave (
      input  st_valid, st_addr, st_data, st_size, mem_ready,
      output st_ready, st_misalign, mem_valid, mem_addr, mem_wdata, mem_be, empty, count
   );

   modport master (
      output st_valid, st_addr, st_data, st_size, mem_ready,
      input  st_ready, st_misalign, mem_valid, mem_addr, mem_wdata, mem_be, empty, count
   );
endinterface

// File: rtl/store_narrow_buffer.sv
// Store narrowing plus DEPTH-entry write buffer; optional tail merge under STORE_COALESCE_EN.
// Push to mem_valid takes 1 cycle; st_ready = !full (no bypass), drain holds head until mem_ready.
module store_narrow_buffer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   store_narrow_buffer_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [29:0]      r_addr [DEPTH];
   logic [31:0]      r_data [DEPTH];
   logic [3:0]       r_be   [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_misalign;

   logic             w_aligned;
   logic [3:0]       w_be_new;
   logic [31:0]      w_wdata_new;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_merge;
   logic             w_alloc;

   always_comb begin
      w_aligned   = 1'b0;
      w_be_new    = 4'b1111;
      w_wdata_new = bus.st_data;
      case (bus.st_size)
         2'b00: begin
            w_aligned   = 1'b1;
            w_be_new    = 4'b0001 << bus.st_addr[1:0];
            w_wdata_new = {4{bus.st_data[7:0]}};
         end
         2'b01: begin
            w_aligned   = !bus.st_addr[0];
            w_be_new    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata_new = {2{bus.st_data[15:0]}};
         end
         2'b10: begin
            w_aligned   = (bus.st_addr[1:0] == 2'b00);
         end
         default: begin
            w_aligned   = 1'b0;
         end
      endcase
   end

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = bus.st_valid && !w_full && w_aligned;
   assign w_pop   = !w_empty && bus.mem_ready;

`ifdef STORE_COALESCE_EN
   logic [PTR_W-1:0] w_tail_ptr;
   assign w_tail_ptr = r_wr_ptr - 1'b1;
   // count>=2 guarantees the tail is never the head being presented to memory
   assign w_merge    = w_push && (r_count >= CNT_W'(2)) &&
                       (r_addr[w_tail_ptr] == bus.st_addr[31:2]);
`else
   assign w_merge    = 1'b0;
`endif
   assign w_alloc = w_push && !w_merge;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= bus.st_valid && !w_full && !w_aligned;
         if (w_alloc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_alloc, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is never read while empty, so it needs no reset.
   always_ff @(posedge i_clk) begin
      if (w_alloc) begin
         r_addr[r_wr_ptr] <= bus.st_addr[31:2];
         r_data[r_wr_ptr] <= w_wdata_new;
         r_be[r_wr_ptr]   <= w_be_new;
      end
`ifdef STORE_COALESCE_EN
      if (w_merge) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be_new[i]) r_data[w_tail_ptr][8*i +: 8] <= w_wdata_new[8*i +: 8];
         end
         r_be[w_tail_ptr] <= r_be[w_tail_ptr] | w_be_new;
      end
`endif
   end

   assign bus.st_ready    = !w_full;
   assign bus.st_misalign = r_misalign;
   assign bus.mem_valid   = !w_empty;
   assign bus.empty       = w_empty;
   assign bus.count       = r_count;
   assign bus.mem_addr    = w_empty ? 32'h0 : {r_addr[r_rd_ptr], 2'b00};
   assign bus.mem_wdata   = w_empty ? 32'h0 : r_data[r_rd_ptr];
   assign bus.mem_be      = w_empty ? 4'h0  : r_be[r_rd_ptr];
endmodule
